// File: rtl/kws_pkg.sv
// Shared definitions for the KWS sample-ingress register block:
// register word offsets, STATUS/CTRL/RESULT bit positions and width defaults.
package kws_pkg;

    localparam int SAMPLE_W_DEF = 16;
    localparam int CLASS_W_DEF  = 4;

    // Word offset inside the 16-byte window, taken from adr[3:2]
    typedef enum logic [1:0] {
        REG_SAMPLE = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RESULT = 2'd3
    } reg_e;

    // STATUS bits
    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_RESV    = 3;
    localparam int ST_CNT_LSB = 8;

    // CTRL bits
    localparam int CTRL_EN      = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_CLR_OVF = 2;

    // RESULT valid flag position
    localparam int RES_VALID_BIT = 31;

endpackage

// File: rtl/kws_wb_sample_ingress_if.sv
// Wishbone slave bus bundle for the KWS sample-ingress block.
interface kws_wb_sample_ingress_if;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/kws_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers so full and empty stay distinct.
// The head output reads 0 whenever the FIFO is empty, so nothing stale leaks out.
module kws_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; flush overrides any same-cycle push or pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents are meaningless once the pointers are cleared
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/kws_wb_sample_ingress.sv
// Wishbone register block feeding audio samples to the KWS core.
// A hit is captured into a request register; the ack cycle is the commit cycle,
// so writes land on the edge that closes the ack and reads are muxed during it.
module kws_wb_sample_ingress
    import kws_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter int          SAMPLE_W  = SAMPLE_W_DEF,
    parameter int          CLASS_W   = CLASS_W_DEF,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n_i,
    kws_wb_sample_ingress_if.slave wb,
    output logic                smp_valid_o,
    output logic [SAMPLE_W-1:0] smp_data_o,
    input  logic                smp_ready_i,
    input  logic                res_valid_i,
    input  logic [CLASS_W-1:0]  res_class_i
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                ack_q;
    logic                we_q;
    logic                sel_ok_q;
    reg_e                reg_q;
    logic [SAMPLE_W-1:0] wdat_q;
    logic                enable_q;
    logic                ovf_q;
    logic                res_vld_q;
    logic [CLASS_W-1:0]  res_class_q;
    logic [31:0]         rdata;

    logic                hit;
    logic                wr_cyc;
    logic                rd_cyc;
    logic                push;
    logic                ovf_set;
    logic                ctrl_wr;
    logic                flush;
    logic                clr_ovf;
    logic                pop;
    logic                full;
    logic                empty;
    logic [CNT_W-1:0]    count;
    logic                unused_bus;

    assign unused_bus = ^{wb.wbs_dat_i, wb.wbs_sel_i, wb.wbs_adr_i};

    assign hit = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q
               & (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);

    assign wr_cyc  = ack_q & we_q;
    assign rd_cyc  = ack_q & ~we_q;
    assign push    = wr_cyc & (reg_q == REG_SAMPLE) & sel_ok_q;
    assign ovf_set = push & full;
    assign ctrl_wr = wr_cyc & (reg_q == REG_CTRL);
    assign flush   = ctrl_wr & wdat_q[CTRL_FLUSH];
    assign clr_ovf = ctrl_wr & wdat_q[CTRL_CLR_OVF];

    assign smp_valid_o = enable_q & ~empty;
    assign pop         = smp_valid_o & smp_ready_i;

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = rdata;

    // Capture the request on a hit; ack follows one cycle later for one cycle
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ack_q    <= 1'b0;
            we_q     <= 1'b0;
            sel_ok_q <= 1'b0;
            reg_q    <= REG_SAMPLE;
            wdat_q   <= '0;
        end else begin
            ack_q <= hit;
            if (hit) begin
                we_q     <= wb.wbs_we_i;
                sel_ok_q <= (wb.wbs_sel_i[1:0] == 2'b11);
                reg_q    <= reg_e'(wb.wbs_adr_i[3:2]);
                wdat_q   <= wb.wbs_dat_i[SAMPLE_W-1:0];
            end
        end
    end

    // Control and status registers committed at the end of the ack cycle
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            enable_q    <= 1'b0;
            ovf_q       <= 1'b0;
            res_vld_q   <= 1'b0;
            res_class_q <= '0;
        end else begin
            if (ctrl_wr) enable_q <= wdat_q[CTRL_EN];
            // An overflowing push beats a simultaneous clear
            if (ovf_set)      ovf_q <= 1'b1;
            else if (clr_ovf) ovf_q <= 1'b0;
            // A fresh result beats the read-to-clear of the old one
            if (res_valid_i) begin
                res_class_q <= res_class_i;
                res_vld_q   <= 1'b1;
            end else if (rd_cyc && reg_q == REG_RESULT) begin
                res_vld_q   <= 1'b0;
            end
        end
    end

    // Read data is driven only during a read ack cycle
    always_comb begin
        rdata = '0;
        if (rd_cyc) begin
            case (reg_q)
                REG_SAMPLE: rdata = '0;
                REG_STATUS: begin
                    rdata[ST_EMPTY]                = empty;
                    rdata[ST_FULL]                 = full;
                    rdata[ST_OVF]                  = ovf_q;
                    rdata[ST_RESV]                 = res_vld_q;
                    rdata[ST_CNT_LSB +: CNT_W]     = count;
                end
                REG_CTRL:   rdata[CTRL_EN] = enable_q;
                REG_RESULT: begin
                    rdata[CLASS_W-1:0]    = res_class_q;
                    rdata[RES_VALID_BIT]  = res_vld_q;
                end
            endcase
        end
    end

    kws_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n_i),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (wdat_q),
        .dout  (smp_data_o),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_kws_wb_sample_ingress.sv
// Directed bench for kws_wb_sample_ingress: Wishbone register accesses,
// sample streaming, overflow, flush, result capture and reset behaviour.
module tb_kws_wb_sample_ingress;

    localparam logic [31:0] A_SAMPLE = 32'h3000_0000;
    localparam logic [31:0] A_STATUS = 32'h3000_0004;
    localparam logic [31:0] A_CTRL   = 32'h3000_0008;
    localparam logic [31:0] A_RESULT = 32'h3000_000C;
    localparam logic [31:0] A_MISS   = 32'h3000_1000;

    logic        clk;
    logic        rst_n;
    logic        smp_valid;
    logic [15:0] smp_data;
    logic        smp_ready;
    logic        res_valid;
    logic [3:0]  res_class;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] rd;
    int          lat;

    kws_wb_sample_ingress_if wb ();

    kws_wb_sample_ingress dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .wb          (wb),
        .smp_valid_o (smp_valid),
        .smp_data_o  (smp_data),
        .smp_ready_i (smp_ready),
        .res_valid_i (res_valid),
        .res_class_i (res_class)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One Wishbone access; returns ack latency in cycles (0 = no ack within budget)
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int budget,
                           output logic [31:0] rdata, output int latency);
        @(posedge clk); #1;
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = we;
        wb.wbs_adr_i = adr;
        wb.wbs_dat_i = dat;
        wb.wbs_sel_i = sel;
        latency = 0;
        rdata   = '0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (wb.wbs_ack_o) begin
                latency = i;
                rdata   = wb.wbs_dat_o;
                break;
            end
        end
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
    endtask

    task automatic wb_wr(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        logic [31:0] d;
        int          l;
        wb_xfer(1'b1, adr, dat, sel, 8, d, l);
        check({tag, "_ack"}, l, 1);
    endtask

    task automatic wb_rd_check(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        int          l;
        wb_xfer(1'b0, adr, 32'h0, 4'hF, 8, d, l);
        check({tag, "_ack"}, l, 1);
        check(tag, d, exp);
    endtask

    initial begin
        rst_n        = 1'b0;
        smp_ready    = 1'b0;
        res_valid    = 1'b0;
        res_class    = 4'h0;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'h0;
        wb.wbs_adr_i = 32'h0;
        wb.wbs_dat_i = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", wb.wbs_ack_o, 0);
        check("rst_dat", wb.wbs_dat_o, 0);
        check("rst_valid", smp_valid, 0);
        check("rst_data", smp_data, 0);
        rst_n = 1'b1;

        // First STATUS read: one-cycle ack latency, empty only
        wb_xfer(1'b0, A_STATUS, 32'h0, 4'hF, 8, rd, lat);
        check("status0_lat", lat, 1);
        check("status0", rd, 32'h0000_0001);
        @(posedge clk); #1;
        check("dat_idle", wb.wbs_dat_o, 0);

        // Enable and stream a single sample straight through
        wb_wr("ctrl_en", A_CTRL, 32'h1, 4'hF);
        wb_rd_check("ctrl_rb", A_CTRL, 32'h1);
        smp_ready = 1'b1;
        wb_wr("push1234", A_SAMPLE, 32'hABCD_1234, 4'hF);
        check("v_in_ack", smp_valid, 0);
        @(posedge clk); #1;
        check("v_after_ack", smp_valid, 1);
        check("d_after_ack", smp_data, 16'h1234);
        @(posedge clk); #1;
        check("v_popped", smp_valid, 0);
        wb_rd_check("status_empty", A_STATUS, 32'h0000_0001);

        // Fill past capacity with the stream disabled
        smp_ready = 1'b0;
        wb_wr("ctrl_dis", A_CTRL, 32'h0, 4'hF);
        for (int i = 0; i < 17; i++) wb_wr("fill", A_SAMPLE, i, 4'h3);
        wb_rd_check("status_full", A_STATUS, 32'h0000_1006);
        check("v_disabled", smp_valid, 0);

        // Drain: samples 0..15 in order, sample 16 was dropped
        smp_ready = 1'b1;
        wb_wr("ctrl_en2", A_CTRL, 32'h1, 4'hF);
        check("v_before_en", smp_valid, 0);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            check("drain_v", smp_valid, 1);
            check("drain_d", smp_data, i);
        end
        @(posedge clk); #1;
        check("drain_end", smp_valid, 0);
        wb_rd_check("status_ovf", A_STATUS, 32'h0000_0005);

        // Hold with ready low, then flush while draining
        smp_ready = 1'b0;
        for (int i = 0; i < 5; i++) wb_wr("fill5", A_SAMPLE, 32'hA0 + i, 4'hF);
        wb_rd_check("status5", A_STATUS, 32'h0000_0504);
        check("head_a0", smp_data, 16'h00A0);
        @(posedge clk); #1;
        check("hold_a0", smp_data, 16'h00A0);
        smp_ready = 1'b1;
        wb_wr("flush", A_CTRL, 32'h3, 4'hF);
        check("v_flush_ack", smp_valid, 1);
        @(posedge clk); #1;
        check("v_flushed", smp_valid, 0);
        wb_rd_check("status_flush", A_STATUS, 32'h0000_0005);

        // Clear overflow; self-clearing CTRL bits read back as 0
        wb_wr("clr_ovf", A_CTRL, 32'h5, 4'hF);
        wb_rd_check("status_clr", A_STATUS, 32'h0000_0001);
        wb_rd_check("ctrl_self_clr", A_CTRL, 32'h1);

        // Result capture and read-to-clear
        smp_ready = 1'b0;
        @(posedge clk); #1;
        res_valid = 1'b1; res_class = 4'h7;
        @(posedge clk); #1;
        res_valid = 1'b0; res_class = 4'h0;
        wb_rd_check("status_resv", A_STATUS, 32'h0000_0009);
        wb_rd_check("result1", A_RESULT, 32'h8000_0007);
        wb_rd_check("result2", A_RESULT, 32'h0000_0007);
        @(posedge clk); #1;
        res_valid = 1'b1; res_class = 4'h9;
        @(posedge clk); #1;
        res_class = 4'h5;
        @(posedge clk); #1;
        res_valid = 1'b0;
        wb_rd_check("result_ovw", A_RESULT, 32'h8000_0005);

        // Partial byte select: acked, ignored
        wb_wr("sel_lo", A_SAMPLE, 32'h0000_BEEF, 4'b0001);
        wb_rd_check("status_sel", A_STATUS, 32'h0000_0001);
        wb_rd_check("sample_rd", A_SAMPLE, 32'h0);
        wb_wr("status_wr", A_STATUS, 32'hFFFF_FFFF, 4'hF);
        wb_rd_check("status_ro", A_STATUS, 32'h0000_0001);

        // Outside the window: no ack at all
        wb_xfer(1'b0, A_MISS, 32'h0, 4'hF, 10, rd, lat);
        check("miss_noack", lat, 0);
        check("miss_dat", rd, 0);
        wb_xfer(1'b1, A_MISS, 32'h1, 4'hF, 10, rd, lat);
        check("miss_wr_noack", lat, 0);
        wb_rd_check("status_miss", A_STATUS, 32'h0000_0001);

        // Reset in the middle of a pending access
        wb_wr("pre_rst1", A_SAMPLE, 32'h55, 4'hF);
        wb_wr("pre_rst2", A_SAMPLE, 32'h66, 4'hF);
        @(posedge clk); #1;
        check("pre_rst_v", smp_valid, 1);
        check("pre_rst_d", smp_data, 16'h0055);
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_adr_i = A_STATUS;
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack", wb.wbs_ack_o, 0);
        @(posedge clk); #1;
        check("mid_rst_ack2", wb.wbs_ack_o, 0);
        check("mid_rst_v", smp_valid, 0);
        check("mid_rst_d", smp_data, 0);
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        rst_n = 1'b1;
        wb_rd_check("post_rst_status", A_STATUS, 32'h0000_0001);
        wb_rd_check("post_rst_ctrl", A_CTRL, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
